// File: rtl/punc_fetch_queue.sv
// punc_fetch_queue: in-order instruction fetch with a DEPTH-entry {word, pc} queue feeding the IR.
module punc_fetch_queue #(
    parameter int DEPTH = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [15:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    input  logic                     halt,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [15:0]              ir_data,
    output logic [15:0]              ir_pc,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   data_q [DEPTH];
    logic [15:0]   pc_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] outstanding, drop, out_next;
    logic [15:0]   fetch_pc, resp_pc;
    logic          rst_q, credit, issue, resp, keep, pop;

    // Credit counts in-flight reads too, so every returned word always has a slot.
    always_comb begin
        credit   = ({1'b0, q_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
        mem_req  = !rst_q && !halt && !redirect && credit;
        mem_addr = fetch_pc;
        issue    = mem_req && mem_gnt;
        resp     = mem_rvalid && outstanding != '0;
        keep     = resp && drop == '0 && !redirect;
        ir_valid = q_count != '0;
        pop      = ir_valid && ir_ready;
        out_next = outstanding + CW'(issue) - CW'(resp);
        ir_data  = ir_valid ? data_q[head] : '0;
        ir_pc    = ir_valid ? pc_q[head] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            head        <= '0;
            tail        <= '0;
            q_count     <= '0;
            outstanding <= '0;
            drop        <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            rst_q       <= 1'b0;
            outstanding <= out_next;
            if (redirect) begin
                head     <= '0;
                tail     <= '0;
                q_count  <= '0;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop     <= out_next;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 16'd1;
                if (resp && drop != '0) drop <= drop - CW'(1);
                if (keep) begin
                    tail    <= tail + AW'(1);
                    resp_pc <= resp_pc + 16'd1;
                end
                if (pop) head <= head + AW'(1);
                q_count <= q_count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            data_q[tail] <= mem_rdata;
            pc_q[tail]   <= resp_pc;
        end
    end

    // A response with nothing in flight is a memory protocol error; it is ignored above.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(mem_rvalid && outstanding == '0));
    end
endmodule
